// File: rtl/pc_cpsr_unit.sv
// pc_cpsr_unit: PC/CPSR stage with fetch-run FSM, commit strobe, next-PC resolve and
// saturating retire/taken counters.
module pc_cpsr_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [31:0]      instr,
  input  logic             branch,
  input  logic             jump,
  input  logic             bvf,
  input  logic             ben,
  input  logic             cpsr_update,
  input  logic             cpsr_reset,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             commit,
  output logic             taken,
  output logic [3:0]       cpsr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] taken_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} state_t;
  state_t      st;
  logic        cond;
  logic [31:0] br_tgt, jmp_tgt, pc_next;
  logic        unused_instr;
  assign unused_instr = ^instr[31:26];
  assign state    = st;
  assign commit   = (st == RUN || st == STALL) && run && imem_ready;
  // bvf/ben look at the flags left by the previous instruction
  assign cond     = (branch & alu_zero) | (bvf & cpsr[0]) | (ben & cpsr[3]);
  assign taken    = commit & (jump | cond);
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign pc_next  = jump ? jmp_tgt : cond ? br_tgt : pc_plus4;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= IDLE;
      pc          <= RESET_PC;
      cpsr        <= 4'd0;
      instr_count <= '0;
      taken_count <= '0;
    end else begin
      st <= (st == IDLE || st == HALT) ? (run ? RUN : st) : (!run ? HALT : imem_ready ? RUN : STALL);
      if (commit) begin
        pc          <= pc_next;
        cpsr        <= cpsr_reset ? 4'd0 : cpsr_update ? {alu_neg, alu_zero, alu_carry, alu_ovf} : cpsr;
        instr_count <= &instr_count ? instr_count : instr_count + 1'b1;
      end
      if (taken)
        taken_count <= &taken_count ? taken_count : taken_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_cpsr_unit.sv
// tb_pc_cpsr_unit: directed vectors for pc_cpsr_unit; a second CNT_W=4 instance
// shares all inputs to exercise counter saturation.
module tb_pc_cpsr_unit;
  logic        clk, reset_n, run, imem_ready;
  logic [31:0] instr;
  logic        branch, jump, bvf, ben, cpsr_update, cpsr_reset;
  logic        alu_zero, alu_neg, alu_carry, alu_ovf;
  logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
  logic        commit, taken, commit_b, taken_b;
  logic [3:0]  cpsr, cpsr_b;
  logic [1:0]  state, state_b;
  logic [31:0] instr_count, taken_count;
  logic [3:0]  instr_count_b, taken_count_b;
  int          n_vec = 0, n_err = 0;

  pc_cpsr_unit dut (
    .clk(clk), .reset_n(reset_n), .run(run), .imem_ready(imem_ready), .instr(instr),
    .branch(branch), .jump(jump), .bvf(bvf), .ben(ben),
    .cpsr_update(cpsr_update), .cpsr_reset(cpsr_reset),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pc(pc), .pc_plus4(pc_plus4), .commit(commit), .taken(taken), .cpsr(cpsr),
    .state(state), .instr_count(instr_count), .taken_count(taken_count)
  );

  pc_cpsr_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run), .imem_ready(imem_ready), .instr(instr),
    .branch(branch), .jump(jump), .bvf(bvf), .ben(ben),
    .cpsr_update(cpsr_update), .cpsr_reset(cpsr_reset),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .commit(commit_b), .taken(taken_b), .cpsr(cpsr_b),
    .state(state_b), .instr_count(instr_count_b), .taken_count(taken_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    instr = 32'd0; branch = 0; jump = 0; bvf = 0; ben = 0;
    cpsr_update = 0; cpsr_reset = 0;
    alu_zero = 0; alu_neg = 0; alu_carry = 0; alu_ovf = 0;
  endtask

  initial begin
    reset_n = 0; run = 0; imem_ready = 0; clr();
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_cpsr", {28'd0, cpsr}, 32'h0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_icnt", instr_count, 32'd0);
    chk("rst_tcnt", taken_count, 32'd0);
    reset_n = 1; run = 1; imem_ready = 1;
    #1;
    chk("idle_commit", {31'd0, commit}, 32'd0);
    // startup: IDLE -> RUN, then sequential fetch
    step();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("seq_pc0", pc, 32'h0);
    chk("run_commit", {31'd0, commit}, 32'd1);
    step(); chk("seq_pc4", pc, 32'h4);
    step(); chk("seq_pc8", pc, 32'h8);
    step(); chk("seq_pc12", pc, 32'hC);
    chk("seq_icnt", instr_count, 32'd3);
    step(); chk("seq_pc16", pc, 32'h10);
    // beq taken backwards
    branch = 1; alu_zero = 1; instr = 32'h0000_FFFE;
    #1; chk("beq_taken", {31'd0, taken}, 32'd1);
    step(); chk("beq_pc", pc, 32'hC); chk("beq_tcnt", taken_count, 32'd1);
    clr(); step(); chk("pc_back16", pc, 32'h10);
    branch = 1; alu_zero = 0; instr = 32'h0000_FFFE;
    #1; chk("beq_nt_taken", {31'd0, taken}, 32'd0);
    step(); chk("beq_nt_pc", pc, 32'h14); chk("beq_nt_tcnt", taken_count, 32'd1);
    // branch to top of address space, then jump across the wrap
    branch = 1; alu_zero = 1; instr = 32'h0000_FFF9;
    step(); chk("br_top_pc", pc, 32'hFFFF_FFFC);
    clr(); jump = 1; instr = 32'h0000_0010;
    #1; chk("wrap_plus4", pc_plus4, 32'h0); chk("jmp_taken", {31'd0, taken}, 32'd1);
    step(); chk("jmp_pc", pc, 32'h40); chk("jmp_tcnt", taken_count, 32'd3);
    clr(); branch = 1; alu_zero = 1; instr = 32'h0000_FFEE;
    step(); chk("br_top2_pc", pc, 32'hFFFF_FFFC);
    clr(); step(); chk("seq_wrap_pc", pc, 32'h0);
    chk("icnt_11", instr_count, 32'd11); chk("tcnt_4", taken_count, 32'd4);
    // bvf / ben on registered flags
    cpsr_update = 1; alu_ovf = 1;
    step(); chk("cpsr_v", {28'd0, cpsr}, 32'h1);
    clr(); bvf = 1; cpsr_reset = 1; cpsr_update = 1; alu_neg = 1; instr = 32'h4;
    #1; chk("bvf_taken", {31'd0, taken}, 32'd1);
    step(); chk("bvf_pc", pc, 32'h18); chk("cpsr_rst_wins", {28'd0, cpsr}, 32'h0);
    clr(); bvf = 1; instr = 32'h4;
    #1; chk("bvf_nt_taken", {31'd0, taken}, 32'd0);
    step(); chk("bvf_nt_pc", pc, 32'h1C);
    clr(); cpsr_update = 1; alu_neg = 1; alu_carry = 1;
    step(); chk("cpsr_nc", {28'd0, cpsr}, 32'hA);
    clr(); ben = 1; instr = 32'h2;
    step(); chk("ben_pc", pc, 32'h2C);
    chk("icnt_16", instr_count, 32'd16); chk("tcnt_6", taken_count, 32'd6);
    // stall then halt then resume
    clr(); imem_ready = 0;
    #1; chk("stall_commit", {31'd0, commit}, 32'd0);
    step(); chk("stall_state", {30'd0, state}, 32'd2); chk("stall_pc", pc, 32'h2C);
    step(); chk("stall_pc2", pc, 32'h2C); chk("stall_icnt", instr_count, 32'd16);
    run = 0;
    step(); chk("halt_state", {30'd0, state}, 32'd3); chk("halt_pc", pc, 32'h2C);
    imem_ready = 1;
    step(); chk("halt_hold", {30'd0, state}, 32'd3);
    chk("halt_commit", {31'd0, commit}, 32'd0); chk("halt_cpsr", {28'd0, cpsr}, 32'hA);
    run = 1;
    step(); chk("resume_state", {30'd0, state}, 32'd1); chk("resume_pc", pc, 32'h2C);
    step(); chk("resume_pc2", pc, 32'h30); chk("icnt_17", instr_count, 32'd17);
    chk("sat_icnt_early", {28'd0, instr_count_b}, 32'd15);
    // asynchronous reset between edges
    #2; reset_n = 0;
    #1;
    chk("arst_pc", pc, 32'h0); chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_cpsr", {28'd0, cpsr}, 32'h0); chk("arst_icnt", instr_count, 32'd0);
    chk("arst_commit", {31'd0, commit}, 32'd0); chk("arst_icnt4", {28'd0, instr_count_b}, 32'd0);
    reset_n = 1;
    step();
    for (int i = 0; i < 14; i++) step();
    chk("cnt4_14", {28'd0, instr_count_b}, 32'd14);
    for (int i = 0; i < 6; i++) step();
    chk("cnt4_sat", {28'd0, instr_count_b}, 32'd15);
    chk("cnt32_20", instr_count, 32'd20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_cpsr_unit.md
# pc_cpsr_unit

Program-counter and condition-status stage of the MIPS-lite 32-bit core. It sits directly downstream of the opcode decoder. It consumes the decoder's `branch`, `jump`, `bvf`, `ben`, `cpsr_update` and `cpsr_reset` strobes together with the ALU flags, holds the PC and the 4-bit CPSR, and resolves the next PC. It also owns the fetch-run state machine, the per-instruction `commit` strobe that gates architectural writes elsewhere, and retire/taken-branch counters.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  core enable; level-sensitive.
- `imem_ready`  in  1  `instr` is valid this cycle.
- `instr`  in  32  current instruction word. Bits [15:0] are the immediate; bits [25:0] are the jump index.
- `branch`, `jump`, `bvf`, `ben`  in  1 each  decoder strobes for the current instruction.
- `cpsr_update`, `cpsr_reset`  in  1 each  decoder CPSR strobes.
- `alu_zero`, `alu_neg`, `alu_carry`, `alu_ovf`  in  1 each  ALU flags for the current instruction.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4` (combinational).
- `commit`  out  1  current instruction retires this cycle.
- `taken`  out  1  commit of a taken branch or jump this cycle.
- `cpsr`  out  4  {N,Z,C,V}, registered.
- `state`  out  2  FSM state: IDLE=0, RUN=1, STALL=2, HALT=3.
- `instr_count`  out  `CNT_W`  retired instructions.
- `taken_count`  out  `CNT_W`  taken branches and jumps.

## Operation
- Reset (`reset_n`=0, asynchronous) sets:
  - `pc`=`RESET_PC`, `cpsr`=0, `state`=IDLE, both counters=0.
  - `commit` and `taken` are then 0, since both depend on state.
- `commit` = (state∈{RUN,STALL}) & `run` & `imem_ready`. It is combinational and is the only enable for register-file and memory writes downstream.
- FSM transitions:
  - IDLE → RUN when `run`=1; otherwise stay in IDLE.
  - RUN and STALL behave identically for all three branches below:
    - `run`=0 → HALT, no commit.
    - `run`=1 and `imem_ready`=0 → STALL.
    - `run`=1 and `imem_ready`=1 → RUN, with commit.
  - HALT → RUN when `run`=1. `pc` and `cpsr` are held throughout HALT; resume is at the held `pc`.
- Branch condition, evaluated on committing cycles only:
  - `beq_t` = `branch` & `alu_zero`.
  - `bvf_t` = `bvf` & `cpsr`[0] (V).
  - `ben_t` = `ben` & `cpsr`[3] (N).
  - `bvf`/`ben` test the registered CPSR, i.e. the flags left by the previous instruction.
- Next-PC priority:
  1. `jump` → {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  2. Else `beq_t`|`bvf_t`|`ben_t` → `pc_plus4` + (sign-extend(`instr`[15:0]) << 2).
  3. Else `pc_plus4`.
- All PC arithmetic is mod 2^32; wrap-around at 32'hFFFF_FFFC is silent.
- `taken` = `commit` & (`jump` | `beq_t` | `bvf_t` | `ben_t`).
- CPSR update, only on committing cycles:
  - `cpsr_reset`=1 → 0. This wins if `cpsr_update` is also 1.
  - Else `cpsr_update`=1 → {`alu_neg`,`alu_zero`,`alu_carry`,`alu_ovf`}.
  - Else hold.
- Counters:
  - `instr_count` increments on `commit`.
  - `taken_count` increments on `taken`.
  - Both saturate at all-ones and never wrap.

## Timing
- Single-cycle core: one instruction retires per cycle while state is RUN or STALL and `run`&`imem_ready`=1.
- `pc`, `cpsr`, counters and `state` change only at the `clk` rising edge, except for asynchronous reset.
- `pc_plus4`, `commit` and `taken` are combinational from current state and inputs, and are valid in the same cycle.
- Latency: a branch resolved in cycle n is fetched at the new `pc` in cycle n+1. There are no delay slots.
- `imem_ready` low: `pc` holds, CPSR holds, counters hold, no write side-effects.
- A reset asserted mid-instruction aborts it: no commit, no CPSR change. Reset deassertion is synchronised externally.
- After reset deassertion the first commit occurs no earlier than one cycle after `run` is seen high, because of the IDLE→RUN transition.

## Test plan
- Reset then start: reset, `run`=1, `imem_ready`=1, no branch strobes for 3 cycles → `pc` steps 0, 4, 8, 12; `instr_count`=3; state IDLE→RUN.
- beq taken: `pc`=0x10, `branch`=1, `alu_zero`=1, imm=0xFFFE → next `pc`=0x0C, `taken`=1, `taken_count` increments. Repeat with `alu_zero`=0 → `pc`=0x14, `taken`=0.
- Jump plus wrap: `pc`=0xFFFF_FFFC, `jump`=1, index=0x0000010 → `pc_plus4`=0, next `pc`=0x40. Separately, sequential step from 0xFFFF_FFFC → 0x0.
- bvf/ben on flags: ADD commit with `cpsr_update`=1, `alu_ovf`=1, `alu_neg`=0 → `cpsr`=4'b0001. Next instruction `bvf`=1, `cpsr_reset`=1, imm=4 → taken, target `pc_plus4`+16, and `cpsr` becomes 0. A following `bvf` is not taken.
- Stall/halt: drop `imem_ready` for 2 cycles mid-run → state STALL, `pc` and counters frozen, `commit`=0. Then `run`=0 → HALT. Then `run`=1 → resume at the same `pc`.
- Async reset mid-run plus saturation: assert `reset_n`=0 between edges → outputs return to reset values immediately. With `CNT_W`=4, commit 20 instructions → `instr_count`=15.
